inst_buffer: RTL and testbench
==============================

Name: inst_buffer

Overview:
- Dual-lane instruction FIFO between fetch and the two `decode` instances.
- Holds {pc, inst} pairs and hands up to two instructions per cycle, in program order, to decode lanes 0/1.
- Absorbs fetch/decode rate mismatch and back-pressure from the `decode_rename_regs` pause request.
- Flushed on branch mispredict or exception redirect.

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 4.
- PTR_W, $clog2(DEPTH), width of the head/tail pointers.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-low
- flush  input  1  discard all entries
- in_valid0  input  1  fetch lane 0 valid (older instruction)
- in_pc0  input  32  lane 0 PC
- in_inst0  input  32  lane 0 instruction word
- in_valid1  input  1  fetch lane 1 valid (younger instruction)
- in_pc1  input  32  lane 1 PC
- in_inst1  input  32  lane 1 instruction word
- in_ready  output  1  buffer can accept two instructions this cycle
- out_ready  input  1  decode accepts this cycle; driven by !pauseReq
- out_valid0  output  1  decode lane 0 valid
- out_pc0  output  32  decode lane 0 PC
- out_inst0  output  32  decode lane 0 instruction word
- out_valid1  output  1  decode lane 1 valid
- out_pc1  output  32  decode lane 1 PC
- out_inst1  output  32  decode lane 1 instruction word
- count  output  PTR_W+1  current occupancy

Behaviour:
- Storage:
  - circular array of DEPTH x 64 bits, pointers head and tail (PTR_W bits, wrap modulo DEPTH), plus a registered occupancy count.
  - Storage contents are not reset; only pointers and count are.
- Reset (rst==0 at posedge): head=0, tail=0, count=0.
  - Outputs follow combinationally: in_ready=1, out_valid0=0, out_valid1=0, out_pc*/out_inst* = 0.
- in_ready = ((DEPTH - count) >= 2).
  - Depends only on registered count, never on same-cycle pop.
- Push, when in_ready && !flush:
  - both lanes valid: write lane0 at tail, lane1 at tail+1; tail += 2.
  - only lane0 valid: write lane0 at tail; tail += 1.
  - only lane1 valid: compact lane1 into entry tail; tail += 1.
  - in_valid* with in_ready=0: ignored, no write. Fetch must hold and re-present.
- Output, combinational from storage:
  - out_valid0 = (count >= 1), showing entry head.
  - out_valid1 = (count >= 2), showing entry head+1 (modulo DEPTH).
  - When invalid, out_pc/out_inst are driven to 0.
- Pop, when out_ready && !flush: head and count advance by out_valid0 + out_valid1 (0, 1 or 2).
  - A single remaining entry always issues on lane 0.
- Simultaneous push and pop: count_next = count + pushed - popped.
  - Both may occur at count == DEPTH-2. Full is never exceeded because in_ready uses the current count.
- Latency: an entry pushed at posedge N is visible on the outputs after posedge N and can be popped at posedge N+1.
- Flush has highest priority:
  - head=tail=0, count=0 next cycle.
  - Same-cycle push and pop are discarded.
  - No output valid in the following cycle.
- Reset mid-operation: identical to flush; all in-flight entries are lost.
- Pointer wrap: tail+1 and head+1 wrap at DEPTH. A 2-wide push or pop straddling index DEPTH-1→0 splits correctly.

Optional Feature:
- Macro: INST_BUF_BYPASS_EN.
- Defined:
  - When count==0 && out_ready && !flush, valid input lanes drive the outputs directly in the same cycle: in_valid0→out_valid0, in_valid1→out_valid1, with lane1-only compacted to lane 0.
  - These lanes are consumed and not written to storage; tail and count are unchanged.
  - If count==0 and !out_ready, normal push applies.
- Undefined:
  - Outputs come from storage only; minimum latency is 1 cycle.
  - No combinational path from in_* to out_*.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release → count=0, in_ready=1, out_valid0=out_valid1=0.
- Fill, out_ready=0: push 4 dual pairs with PCs 0x00..0x1C → count=8, in_ready=0. A 5th pair with PC 0x20 is ignored and count stays 8.
- Drain, out_ready=1, no push:
  - cycle 1 → lanes show PC 0x00 / 0x04;
  - following cycles → 0x08/0x0C, 0x10/0x14, 0x18/0x1C;
  - then out_valid0=0.
- Odd occupancy: push lane0-only PC 0x40, then pop → out_valid0=1, out_pc0=0x40, out_valid1=0, count returns to 0.
- Wrap with simultaneous push/pop: with head=7 and count=2, push a pair and pop 2 in one cycle → count=2, outputs in order across the 7→0 wrap.
- Flush: with count=6, assert flush together with a push and out_ready=1 → next cycle count=0, out_valid0=0, nothing written. Without the macro, the first cycle after flush shows no valid output.

Source files
------------

// File: rtl/inst_buffer.sv
// inst_buffer: dual-lane instruction FIFO between fetch and the two decode lanes.
//
// Holds {pc, inst} pairs in a DEPTH-entry circular buffer. Accepts up to two
// instructions per cycle from fetch and hands up to two per cycle, in program
// order, to decode lanes 0/1. Flush discards all entries.
//
// Optional build macro: INST_BUF_BYPASS_EN
//   When defined, an empty buffer with decode ready forwards the incoming fetch
//   lanes straight to the outputs in the same cycle without storing them.
//   When undefined, outputs come from storage only (no in_* -> out_* path).
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   flush               discard all entries (highest priority)
//   in_valid0/pc0/inst0 fetch lane 0 (older)
//   in_valid1/pc1/inst1 fetch lane 1 (younger)
//   in_ready            room for two instructions this cycle
//   out_ready           decode accepts this cycle
//   out_valid0/pc0/inst0 decode lane 0
//   out_valid1/pc1/inst1 decode lane 1
//   count               current occupancy
module inst_buffer #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid0,
    input  logic [31:0]      in_pc0,
    input  logic [31:0]      in_inst0,
    input  logic             in_valid1,
    input  logic [31:0]      in_pc1,
    input  logic [31:0]      in_inst1,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             out_valid0,
    output logic [31:0]      out_pc0,
    output logic [31:0]      out_inst0,
    output logic             out_valid1,
    output logic [31:0]      out_pc1,
    output logic [31:0]      out_inst1,
    output logic [PTR_W:0]   count
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    logic [PTR_W-1:0] w_head1;
    logic [PTR_W-1:0] w_tail1;
    logic             w_st_v0;
    logic             w_st_v1;
    logic             w_byp;
    logic             w_push_en;
    logic [1:0]       w_push_n;
    logic [1:0]       w_pop_n;
    entry_t           w_lane0;
    entry_t           w_lane1;
    entry_t           w_wr0;
    entry_t           w_ent_h0;
    entry_t           w_ent_h1;

    assign w_head1 = r_head + 1'b1;
    assign w_tail1 = r_tail + 1'b1;
    assign w_lane0 = '{pc: in_pc0, inst: in_inst0};
    assign w_lane1 = '{pc: in_pc1, inst: in_inst1};
    // Lane1-only pushes are compacted into the tail slot.
    assign w_wr0   = in_valid0 ? w_lane0 : w_lane1;

    // Readiness looks only at the registered count, so a same-cycle pop never
    // opens a combinational path from decode back to fetch.
    assign in_ready = (r_count <= (PTR_W+1)'(DEPTH - 2));
    assign count    = r_count;

    assign w_st_v0 = (r_count != '0);
    assign w_st_v1 = (r_count >  (PTR_W+1)'(1));

`ifdef INST_BUF_BYPASS_EN
    assign w_byp = (r_count == '0) && out_ready && !flush;
`else
    assign w_byp = 1'b0;
`endif

    // Bypassed lanes are consumed directly and never enter storage.
    assign w_push_en = rst && in_ready && !flush && !w_byp;
    assign w_push_n  = w_push_en ? ({1'b0, in_valid0} + {1'b0, in_valid1}) : 2'd0;
    assign w_pop_n   = (out_ready && !flush) ? ({1'b0, w_st_v0} + {1'b0, w_st_v1}) : 2'd0;

    assign w_ent_h0 = r_mem[r_head];
    assign w_ent_h1 = r_mem[w_head1];

    always_comb begin
        out_valid0 = w_st_v0;
        out_pc0    = w_st_v0 ? w_ent_h0.pc   : 32'd0;
        out_inst0  = w_st_v0 ? w_ent_h0.inst : 32'd0;
        out_valid1 = w_st_v1;
        out_pc1    = w_st_v1 ? w_ent_h1.pc   : 32'd0;
        out_inst1  = w_st_v1 ? w_ent_h1.inst : 32'd0;
`ifdef INST_BUF_BYPASS_EN
        if (w_byp) begin
            out_valid0 = in_valid0 || in_valid1;
            out_pc0    = (in_valid0 || in_valid1) ? w_wr0.pc   : 32'd0;
            out_inst0  = (in_valid0 || in_valid1) ? w_wr0.inst : 32'd0;
            out_valid1 = in_valid0 && in_valid1;
            out_pc1    = (in_valid0 && in_valid1) ? in_pc1     : 32'd0;
            out_inst1  = (in_valid0 && in_valid1) ? in_inst1   : 32'd0;
        end
`endif
    end

    // Storage is intentionally not reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push_en && (in_valid0 || in_valid1))
            r_mem[r_tail] <= w_wr0;
        if (w_push_en && in_valid0 && in_valid1)
            r_mem[w_tail1] <= w_lane1;
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_pop_n);
            r_tail  <= r_tail + PTR_W'(w_push_n);
            r_count <= r_count + (PTR_W+1)'(w_push_n) - (PTR_W+1)'(w_pop_n);
        end
    end

endmodule

// File: tb/tb_inst_buffer.sv
module tb_inst_buffer;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid0, in_valid1;
    logic [31:0] in_pc0, in_inst0, in_pc1, in_inst1;
    logic        in_ready;
    logic        out_ready;
    logic        out_valid0, out_valid1;
    logic [31:0] out_pc0, out_inst0, out_pc1, out_inst1;
    logic [PTR_W:0] count;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    inst_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid0(in_valid0), .in_pc0(in_pc0), .in_inst0(in_inst0),
        .in_valid1(in_valid1), .in_pc1(in_pc1), .in_inst1(in_inst1),
        .in_ready(in_ready), .out_ready(out_ready),
        .out_valid0(out_valid0), .out_pc0(out_pc0), .out_inst0(out_inst0),
        .out_valid1(out_valid1), .out_pc1(out_pc1), .out_inst1(out_inst1),
        .count(count)
    );

    typedef struct {
        logic        fl, rdy, v0, v1;
        logic [31:0] pc0, pc1;
        logic        e_inr, e_ov0, e_ov1;
        int          e_cnt;
        logic [31:0] e_pc0, e_pc1;
    } vec_t;

    vec_t tv[$];

    // Instruction word tied to its PC so inst routing is checked too.
    function automatic logic [31:0] iw(input logic [31:0] pc);
        return pc + 32'h1000_0000;
    endfunction

    function automatic vec_t mk(input logic fl, rdy, v0, input logic [31:0] pc0,
                                input logic v1, input logic [31:0] pc1,
                                input logic inr, input int cnt,
                                input logic ov0, input logic [31:0] epc0,
                                input logic ov1, input logic [31:0] epc1);
        vec_t v;
        v.fl = fl; v.rdy = rdy; v.v0 = v0; v.pc0 = pc0; v.v1 = v1; v.pc1 = pc1;
        v.e_inr = inr; v.e_cnt = cnt; v.e_ov0 = ov0; v.e_pc0 = epc0;
        v.e_ov1 = ov1; v.e_pc1 = epc1;
        return v;
    endfunction

    task automatic drive(input logic fl, rdy, v0, input logic [31:0] pc0,
                         input logic v1, input logic [31:0] pc1);
        flush = fl; out_ready = rdy;
        in_valid0 = v0; in_pc0 = pc0; in_inst0 = iw(pc0);
        in_valid1 = v1; in_pc1 = pc1; in_inst1 = iw(pc1);
    endtask

    task automatic chk1(input string nm, input logic [31:0] act, exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Outputs reflect the state registered before the upcoming posedge.
    task automatic check(input string tag, input logic inr, input int cnt,
                         input logic ov0, input logic [31:0] pc0,
                         input logic ov1, input logic [31:0] pc1);
        n_vec++;
        chk1({tag, ".in_ready"},   {31'd0, in_ready},   {31'd0, inr});
        chk1({tag, ".count"},      {28'd0, count},      cnt);
        chk1({tag, ".out_valid0"}, {31'd0, out_valid0}, {31'd0, ov0});
        chk1({tag, ".out_pc0"},    out_pc0,   ov0 ? pc0 : 32'd0);
        chk1({tag, ".out_inst0"},  out_inst0, ov0 ? iw(pc0) : 32'd0);
        chk1({tag, ".out_valid1"}, {31'd0, out_valid1}, {31'd0, ov1});
        chk1({tag, ".out_pc1"},    out_pc1,   ov1 ? pc1 : 32'd0);
        chk1({tag, ".out_inst1"},  out_inst1, ov1 ? iw(pc1) : 32'd0);
    endtask

    initial begin
        // fl rdy v0 pc0 v1 pc1 | inr cnt ov0 pc0 ov1 pc1
        // reset state, then fill with out_ready=0
        tv.push_back(mk(0,0,0,32'h00,0,32'h00, 1,0, 0,32'h00,0,32'h00));
        tv.push_back(mk(0,0,1,32'h00,1,32'h04, 1,0, 0,32'h00,0,32'h00));
        tv.push_back(mk(0,0,1,32'h08,1,32'h0C, 1,2, 1,32'h00,1,32'h04));
        tv.push_back(mk(0,0,1,32'h10,1,32'h14, 1,4, 1,32'h00,1,32'h04));
        tv.push_back(mk(0,0,1,32'h18,1,32'h1C, 1,6, 1,32'h00,1,32'h04));
        tv.push_back(mk(0,0,1,32'h20,1,32'h24, 0,8, 1,32'h00,1,32'h04));
        tv.push_back(mk(0,0,0,32'h00,0,32'h00, 0,8, 1,32'h00,1,32'h04));
        // drain two per cycle
        tv.push_back(mk(0,1,0,32'h00,0,32'h00, 0,8, 1,32'h00,1,32'h04));
        tv.push_back(mk(0,1,0,32'h00,0,32'h00, 1,6, 1,32'h08,1,32'h0C));
        tv.push_back(mk(0,1,0,32'h00,0,32'h00, 1,4, 1,32'h10,1,32'h14));
        tv.push_back(mk(0,1,0,32'h00,0,32'h00, 1,2, 1,32'h18,1,32'h1C));
        tv.push_back(mk(0,0,0,32'h00,0,32'h00, 1,0, 0,32'h00,0,32'h00));
        // odd occupancy: single entry issues on lane 0
        tv.push_back(mk(0,0,1,32'h40,0,32'h00, 1,0, 0,32'h00,0,32'h00));
        tv.push_back(mk(0,1,0,32'h00,0,32'h00, 1,1, 1,32'h40,0,32'h00));
        tv.push_back(mk(0,0,0,32'h00,0,32'h00, 1,0, 0,32'h00,0,32'h00));
        // head=tail=1: walk head to 7, incl. lane1-only compaction
        tv.push_back(mk(0,0,1,32'hA0,1,32'hA4, 1,0, 0,32'h00,0,32'h00));
        tv.push_back(mk(0,0,1,32'hA8,1,32'hAC, 1,2, 1,32'hA0,1,32'hA4));
        tv.push_back(mk(0,0,0,32'h00,1,32'hB0, 1,4, 1,32'hA0,1,32'hA4));
        tv.push_back(mk(0,1,1,32'hB4,0,32'h00, 1,5, 1,32'hA0,1,32'hA4));
        tv.push_back(mk(0,1,0,32'h00,0,32'h00, 1,4, 1,32'hA8,1,32'hAC));
        tv.push_back(mk(0,1,0,32'h00,0,32'h00, 1,2, 1,32'hB0,1,32'hB4));
        // head=tail=7: push pair straddling 7->0, then push+pop together
        tv.push_back(mk(0,0,1,32'hC0,1,32'hC4, 1,0, 0,32'h00,0,32'h00));
        tv.push_back(mk(0,1,1,32'hC8,1,32'hCC, 1,2, 1,32'hC0,1,32'hC4));
        tv.push_back(mk(0,0,0,32'h00,0,32'h00, 1,2, 1,32'hC8,1,32'hCC));
        // flush at count 6 with push and pop
        tv.push_back(mk(0,0,1,32'hD0,1,32'hD4, 1,2, 1,32'hC8,1,32'hCC));
        tv.push_back(mk(0,0,1,32'hD8,1,32'hDC, 1,4, 1,32'hC8,1,32'hCC));
        tv.push_back(mk(1,1,1,32'hE0,1,32'hE4, 1,6, 1,32'hC8,1,32'hCC));
        tv.push_back(mk(0,1,0,32'h00,0,32'h00, 1,0, 0,32'h00,0,32'h00));
        tv.push_back(mk(0,0,1,32'hF0,1,32'hF4, 1,0, 0,32'h00,0,32'h00));
        tv.push_back(mk(0,1,0,32'h00,0,32'h00, 1,2, 1,32'hF0,1,32'hF4));
        tv.push_back(mk(0,0,0,32'h00,0,32'h00, 1,0, 0,32'h00,0,32'h00));
        // count 7 boundary: one free slot is not enough for in_ready
        tv.push_back(mk(0,0,1,32'h10,1,32'h14, 1,0, 0,32'h00,0,32'h00));
        tv.push_back(mk(0,0,1,32'h18,1,32'h1C, 1,2, 1,32'h10,1,32'h14));
        tv.push_back(mk(0,0,1,32'h20,1,32'h24, 1,4, 1,32'h10,1,32'h14));
        tv.push_back(mk(0,0,1,32'h28,0,32'h00, 1,6, 1,32'h10,1,32'h14));
        tv.push_back(mk(0,0,1,32'h30,1,32'h34, 0,7, 1,32'h10,1,32'h14));
        tv.push_back(mk(0,0,0,32'h00,0,32'h00, 0,7, 1,32'h10,1,32'h14));

        rst = 1'b0;
        drive(0, 0, 0, 32'h0, 0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        foreach (tv[i]) begin
            drive(tv[i].fl, tv[i].rdy, tv[i].v0, tv[i].pc0, tv[i].v1, tv[i].pc1);
            #1;
            check($sformatf("v%0d", i), tv[i].e_inr, tv[i].e_cnt,
                  tv[i].e_ov0, tv[i].e_pc0, tv[i].e_ov1, tv[i].e_pc1);
            @(negedge clk);
        end

        // Reset mid-operation behaves like flush, even with push+pop pending.
        rst = 1'b0;
        drive(0, 1, 1, 32'h40, 1, 32'h44);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 32'h0, 0, 32'h0);
        #1;
        check("rst_mid", 1, 0, 0, 32'h0, 0, 32'h0);
        @(negedge clk);
        #1;
        check("rst_idle", 1, 0, 0, 32'h0, 0, 32'h0);
        drive(0, 0, 1, 32'h50, 1, 32'h54);
        @(negedge clk);
        drive(0, 0, 0, 32'h0, 0, 32'h0);
        #1;
        check("rst_push", 1, 2, 1, 32'h50, 1, 32'h54);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
